// File: rtl/bra_upd_ctl_pkg.sv
// Shared types and default widths for the branch-resolution update controller.
// Optional statistics counters are enabled with the BRU_STATS_EN macro.
package bra_upd_ctl_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int GHR_WIDTH     = 14;
  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    BRU_IDLE = 2'd0,
    BRU_UPD  = 2'd1,
    BRU_REC  = 2'd2
  } bru_state_e;

  // Queue entry layout is {pc, ghr, predicted_taken}.
  function automatic int brq_entry_width(input int addr_w, input int ghr_w);
    return addr_w + ghr_w + 1;
  endfunction

endpackage

// File: rtl/bra_chk_fifo.sv
// In-order prediction queue: circular FIFO with an extra pointer MSB for
// full/empty, plus a clear that discards every entry and rewinds the pointers.
module bra_chk_fifo #(
  parameter int W     = 47,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok, pop_ok;

  assign full      = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign dout      = mem[rd_ptr_q[PW-1:0]];

  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[PW-1:0]] <= din;
  end

endmodule

// File: rtl/bra_upd_ctl.sv
// Branch-resolution update controller: pops queued predictions on in-order
// resolution and drives PAs/selector update and GHR repair. BRU_STATS_EN adds counters.
module bra_upd_ctl
  import bra_upd_ctl_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int GHR_W  = GHR_WIDTH,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pre_valid,
  output logic                     pre_ready,
  input  logic [ADDR_W-1:0]        pre_addr,
  input  logic                     pre_torn,
  input  logic [GHR_W-1:0]         pre_ghr,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic                     res_taken,
  output logic [ADDR_W-1:0]        up_addr,
  output logic                     PAs_up_en,
  output logic                     PAs_wr_data,
  output logic                     torf,
  output logic                     gshare_reen,
  output logic [GHR_W-1:0]         re_GHR,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]              stat_res,
  output logic [15:0]              stat_mis
`endif
);

  localparam int EW = brq_entry_width(ADDR_W, GHR_W);

  bru_state_e        state_q, state_d;
  logic [ADDR_W-1:0] up_addr_q, up_addr_d;
  logic              pas_up_en_q, pas_up_en_d;
  logic              pas_wr_data_q, pas_wr_data_d;
  logic              torf_q, torf_d;
  logic              gshare_reen_q, gshare_reen_d;
  logic [GHR_W-1:0]  re_ghr_q, re_ghr_d;
  logic              flush_q, flush_d;

  logic [EW-1:0]     head;
  logic              full, empty;
  logic              push, res_fire, mispredict;
  logic [ADDR_W-1:0] head_pc;
  logic [GHR_W-1:0]  head_ghr;
  logic              head_torn;

  assign head_pc   = head[EW-1 -: ADDR_W];
  assign head_ghr  = head[GHR_W:1];
  assign head_torn = head[0];

  assign pre_ready  = !full && (state_q != BRU_REC);
  assign res_ready  = (state_q == BRU_IDLE) && !empty;
  assign push       = pre_valid && pre_ready;
  assign res_fire   = res_valid && res_ready;
  assign mispredict = res_fire && (res_taken != head_torn);

  // A mispredict clears the whole queue, which also swallows a same-edge push.
  bra_chk_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (res_fire),
    .clear     (mispredict),
    .din       ({pre_addr, pre_ghr, pre_torn}),
    .dout      (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pas_up_en_d   = 1'b0;
    torf_d        = 1'b0;
    gshare_reen_d = 1'b0;
    flush_d       = 1'b0;
    up_addr_d     = up_addr_q;
    pas_wr_data_d = pas_wr_data_q;
    re_ghr_d      = re_ghr_q;
    unique case (state_q)
      BRU_IDLE: begin
        if (res_fire) begin
          state_d       = mispredict ? BRU_REC : BRU_UPD;
          pas_up_en_d   = 1'b1;
          pas_wr_data_d = res_taken;
          torf_d        = !mispredict;
          up_addr_d     = head_pc;
          if (mispredict) begin
            gshare_reen_d = 1'b1;
            flush_d       = 1'b1;
            re_ghr_d      = {head_ghr[GHR_W-2:0], res_taken};
          end
        end
      end
      BRU_UPD, BRU_REC: state_d = BRU_IDLE;
      default:          state_d = BRU_IDLE;
    endcase
  end

`ifdef BRU_STATS_EN
  logic [15:0] stat_res_q, stat_res_d;
  logic [15:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_res_d = stat_res_q;
    stat_mis_d = stat_mis_q;
    if (state_d == BRU_UPD && state_q != BRU_UPD && stat_res_q != 16'hFFFF)
      stat_res_d = stat_res_q + 16'd1;
    if (state_d == BRU_REC && state_q != BRU_REC && stat_mis_q != 16'hFFFF)
      stat_mis_d = stat_mis_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_res = stat_res_q;
  assign stat_mis = stat_mis_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BRU_IDLE;
      up_addr_q     <= '0;
      pas_up_en_q   <= 1'b0;
      pas_wr_data_q <= 1'b0;
      torf_q        <= 1'b0;
      gshare_reen_q <= 1'b0;
      re_ghr_q      <= '0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      up_addr_q     <= up_addr_d;
      pas_up_en_q   <= pas_up_en_d;
      pas_wr_data_q <= pas_wr_data_d;
      torf_q        <= torf_d;
      gshare_reen_q <= gshare_reen_d;
      re_ghr_q      <= re_ghr_d;
      flush_q       <= flush_d;
    end
  end

  assign up_addr     = up_addr_q;
  assign PAs_up_en   = pas_up_en_q;
  assign PAs_wr_data = pas_wr_data_q;
  assign torf        = torf_q;
  assign gshare_reen = gshare_reen_q;
  assign re_GHR      = re_ghr_q;
  assign flush       = flush_q;

endmodule

// File: tb/tb_bra_upd_ctl.sv
// Directed bench for bra_upd_ctl; define BRU_STATS_EN to also check the counters.
module tb_bra_upd_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pre_valid, pre_torn, res_valid, res_taken;
  logic [31:0] pre_addr;
  logic [13:0] pre_ghr;
  logic        pre_ready, res_ready;
  logic [31:0] up_addr;
  logic        PAs_up_en, PAs_wr_data, torf, gshare_reen, flush;
  logic [13:0] re_GHR;
  logic [3:0]  occupancy;
`ifdef BRU_STATS_EN
  logic [15:0] stat_res, stat_mis;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bra_upd_ctl #(.ADDR_W(32), .GHR_W(14), .DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .pre_valid   (pre_valid),
    .pre_ready   (pre_ready),
    .pre_addr    (pre_addr),
    .pre_torn    (pre_torn),
    .pre_ghr     (pre_ghr),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_taken   (res_taken),
    .up_addr     (up_addr),
    .PAs_up_en   (PAs_up_en),
    .PAs_wr_data (PAs_wr_data),
    .torf        (torf),
    .gshare_reen (gshare_reen),
    .re_GHR      (re_GHR),
    .flush       (flush),
    .occupancy   (occupancy)
`ifdef BRU_STATS_EN
    ,
    .stat_res    (stat_res),
    .stat_mis    (stat_mis)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled only at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push1(input logic [31:0] a, input logic t, input logic [13:0] g);
    pre_valid = 1'b1; pre_addr = a; pre_torn = t; pre_ghr = g;
    tick();
    pre_valid = 1'b0;
  endtask

  task automatic resolve(input logic t);
    res_valid = 1'b1; res_taken = t;
    tick();
    res_valid = 1'b0;
  endtask

  logic [31:0] prev_addr;
  logic        prev_torn;
  logic [1:0]  exp_en [6];
  logic [1:0]  exp_rr [6];

  initial begin
    reset = 1'b0; pre_valid = 1'b0; pre_torn = 1'b0; pre_addr = '0; pre_ghr = '0;
    res_valid = 1'b0; res_taken = 1'b0;
    tick(); tick();
    check("rst_pre_ready", {31'd0, pre_ready}, 32'd1);
    check("rst_res_ready", {31'd0, res_ready}, 32'd0);
    check("rst_occ", {28'd0, occupancy}, 32'd0);
    check("rst_strobes", {28'd0, PAs_up_en, torf, gshare_reen, flush}, 32'd0);
    check("rst_up_addr", up_addr, 32'd0);
    check("rst_re_ghr", {18'd0, re_GHR}, 32'd0);
    reset = 1'b1;
    tick();

    // Single correct prediction.
    push1(32'h1000, 1'b1, 14'h0005);
    check("t1_occ1", {28'd0, occupancy}, 32'd1);
    check("t1_res_ready", {31'd0, res_ready}, 32'd1);
    resolve(1'b1);
    check("t1_en", {31'd0, PAs_up_en}, 32'd1);
    check("t1_torf", {31'd0, torf}, 32'd1);
    check("t1_wr_data", {31'd0, PAs_wr_data}, 32'd1);
    check("t1_up_addr", up_addr, 32'h1000);
    check("t1_reen_flush", {30'd0, gshare_reen, flush}, 32'd0);
    check("t1_occ0", {28'd0, occupancy}, 32'd0);
    check("t1_res_ready_upd", {31'd0, res_ready}, 32'd0);
    tick();
    check("t1_en_off", {31'd0, PAs_up_en}, 32'd0);
    check("t1_addr_hold", up_addr, 32'h1000);

    // Mispredict on the oldest of three; a same-edge push is discarded.
    push1(32'h2000, 1'b1, 14'h1ABC);
    push1(32'h2004, 1'b0, 14'h0123);
    push1(32'h2008, 1'b1, 14'h0456);
    check("t2_occ3", {28'd0, occupancy}, 32'd3);
    pre_valid = 1'b1; pre_addr = 32'h3000; pre_torn = 1'b0; pre_ghr = 14'h0;
    resolve(1'b0);
    pre_valid = 1'b0;
    check("t2_reen", {31'd0, gshare_reen}, 32'd1);
    check("t2_flush", {31'd0, flush}, 32'd1);
    check("t2_re_ghr", {18'd0, re_GHR}, 32'h3578);
    check("t2_torf", {31'd0, torf}, 32'd0);
    check("t2_en", {31'd0, PAs_up_en}, 32'd1);
    check("t2_wr_data", {31'd0, PAs_wr_data}, 32'd0);
    check("t2_up_addr", up_addr, 32'h2000);
    check("t2_occ0", {28'd0, occupancy}, 32'd0);
    check("t2_pre_ready_rec", {31'd0, pre_ready}, 32'd0);
    tick();
    check("t2_reen_off", {30'd0, gshare_reen, flush}, 32'd0);
    check("t2_ghr_hold", {18'd0, re_GHR}, 32'h3578);
    check("t2_pre_ready", {31'd0, pre_ready}, 32'd1);
    check("t2_occ_after", {28'd0, occupancy}, 32'd0);

    // Fill to capacity; the ninth push must be ignored.
    for (int i = 0; i < 8; i++) push1(32'h4000 + 32'(4 * i), 1'b0, 14'(i));
    check("t3_full_ready", {31'd0, pre_ready}, 32'd0);
    check("t3_occ8", {28'd0, occupancy}, 32'd8);
    push1(32'h4FFC, 1'b0, 14'h3FFF);
    check("t3_occ8_drop", {28'd0, occupancy}, 32'd8);
    resolve(1'b0);
    check("t3_up_addr0", up_addr, 32'h4000);
    check("t3_torf", {31'd0, torf}, 32'd1);
    check("t3_pre_ready", {31'd0, pre_ready}, 32'd1);
    check("t3_occ7", {28'd0, occupancy}, 32'd7);
    for (int k = 1; k < 8; k++) begin
      tick();
      resolve(1'b0);
      check("t3_drain_addr", up_addr, 32'h4000 + 32'(4 * k));
    end
    check("t3_empty", {28'd0, occupancy}, 32'd0);
    tick();
    check("t3_no_res_ready", {31'd0, res_ready}, 32'd0);

    // Twenty entries with push+pop on the same edge; order kept across wrap.
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
        pre_valid = 1'b1; pre_addr = 32'h5000 + 32'(4 * i);
        pre_torn = (i % 3 == 0); pre_ghr = 14'(i);
      end
      if (i > 0) begin
        res_valid = 1'b1; res_taken = prev_torn;
      end
      tick();
      pre_valid = 1'b0; res_valid = 1'b0;
      if (i > 0) begin
        check("t4_en", {31'd0, PAs_up_en}, 32'd1);
        check("t4_up_addr", up_addr, prev_addr);
        check("t4_torf", {31'd0, torf}, 32'd1);
        check("t4_occ", {28'd0, occupancy}, (i < 20) ? 32'd1 : 32'd0);
      end
      prev_addr = 32'h5000 + 32'(4 * i);
      prev_torn = (i % 3 == 0);
      tick();
    end

    // res_valid held high: strobes only in alternate cycles, none once empty.
    push1(32'h6000, 1'b1, 14'h0011);
    push1(32'h6004, 1'b1, 14'h0022);
    exp_en = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
    exp_rr = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    res_valid = 1'b1; res_taken = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t5_en", {31'd0, PAs_up_en}, {30'd0, exp_en[c]});
      check("t5_res_ready", {31'd0, res_ready}, {30'd0, exp_rr[c]});
      if (c == 0) check("t5_addr0", up_addr, 32'h6000);
      if (c == 2) check("t5_addr1", up_addr, 32'h6004);
    end
    res_valid = 1'b0;
    check("t5_addr_hold", up_addr, 32'h6004);

    // Mispredict, then reset asserted in the middle of the REC cycle.
    push1(32'h7000, 1'b1, 14'h2AAA);
    push1(32'h7004, 1'b0, 14'h0001);
    resolve(1'b0);
    check("t6_reen", {31'd0, gshare_reen}, 32'd1);
    check("t6_re_ghr", {18'd0, re_GHR}, 32'h1554);
    check("t6_up_addr", up_addr, 32'h7000);
`ifdef BRU_STATS_EN
    check("stat_res", {16'd0, stat_res}, 32'd31);
    check("stat_mis", {16'd0, stat_mis}, 32'd2);
`endif
    #1 reset = 1'b0;
    #1;
    check("t6_rst_reen_flush", {30'd0, gshare_reen, flush}, 32'd0);
    check("t6_rst_en", {31'd0, PAs_up_en}, 32'd0);
    check("t6_rst_occ", {28'd0, occupancy}, 32'd0);
    check("t6_rst_pre_ready", {31'd0, pre_ready}, 32'd1);
`ifdef BRU_STATS_EN
    check("stat_rst", {stat_res, stat_mis}, 32'd0);
`endif
    tick();
    reset = 1'b1;
    tick();
    check("t6_idle_after", {31'd0, res_ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bra_upd_ctl.md
Name: bra_upd_ctl

Overview:
- Resolution-side companion of the branch predictor top.
- Queues every issued prediction together with its PC and GHR snapshot, in order.
- On in-order branch resolution, pops the oldest entry and generates the predictor update strobes: PAs history write, selector train, up_addr.
- On a mispredict, also drives GHR repair (gshare_reen/re_GHR) and squashes all younger queued predictions.

Parameters:
ADDR_W, 32, branch PC width
GHR_W, 14, global history width; matches predictor GHR
DEPTH, 8, in-flight prediction queue entries; power of two, >=2

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pre_valid  in  1  prediction issued this cycle
pre_ready  out  1  queue can accept a prediction
pre_addr  in  ADDR_W  PC of predicted branch
pre_torn  in  1  predicted direction (1 = taken)
pre_ghr  in  GHR_W  GHR value used for this prediction
res_valid  in  1  oldest branch resolved
res_ready  out  1  controller accepts resolution
res_taken  in  1  actual direction
up_addr  out  ADDR_W  PC of the branch being updated
PAs_up_en  out  1  one-cycle PAs BHT update strobe
PAs_wr_data  out  1  actual direction for PAs/FSM training
torf  out  1  1 = prediction correct; selector training
gshare_reen  out  1  one-cycle GHR restore strobe
re_GHR  out  GHR_W  repaired GHR value
flush  out  1  one-cycle squash of younger front-end state
occupancy  out  log2(DEPTH)+1  queue entries in use

Behaviour:
- Reset (async, active-low): queue empty, state IDLE. All outputs 0 except pre_ready=1.
- Queue:
  - Circular FIFO. Pointers are log2(DEPTH)+1 bits; full/empty derive from the extra MSB.
  - Push on pre_valid&&pre_ready.
  - pre_ready = !full && state!=REC.
  - Push while full or while pre_ready=0 is dropped; no state change.
- FSM states: IDLE, UPD, REC.
  - res_ready = (state==IDLE) && !empty.
  - res_valid while empty or not IDLE is ignored.
  - On res handshake (edge N), pop the head entry. Next state is UPD if res_taken==pre_torn, else REC.
  - UPD (cycle N+1): PAs_up_en=1, PAs_wr_data=res_taken, torf=1, up_addr=entry PC, gshare_reen=0, flush=0. Next state IDLE.
  - REC (cycle N+1): PAs_up_en=1, PAs_wr_data=res_taken, torf=0, up_addr=entry PC, gshare_reen=1, flush=1, re_GHR={entry_ghr[GHR_W-2:0],res_taken}. Next state IDLE.
  - REC squash: queue is cleared at edge N (pop plus discard of all younger entries), so occupancy=0 in cycle N+1.
  - Strobes are single-cycle and registered. Latency from res handshake to strobe is exactly 1 cycle. Max resolution rate is 1 per 2 cycles.
- Simultaneous events:
  - Push and pop at the same correct-resolution edge: both occur; occupancy unchanged.
  - Push at a mispredict edge: the push is discarded along with the squash.
- Outputs outside UPD/REC: all strobes 0. up_addr, PAs_wr_data and re_GHR hold their last values.
- Pointer wrap-around at DEPTH is seamless; there is no reset of pointers except on squash/reset.
- Reset asserted mid-UPD/REC: strobes clear immediately (async).

Optional Feature:
- Macro BRU_STATS_EN.
- When defined:
  - Adds outputs stat_res[15:0] (resolutions) and stat_mis[15:0] (mispredicts).
  - Both increment on entry to UPD/REC respectively and saturate at 16'hFFFF.
  - Both reset to 0.
- When not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared header (alongside existing predictor header):
  - `ADDR_WIDTH and `GHR_WIDTH reused.
  - New `BRQ_ENTRY_WIDTH (ADDR_W+GHR_W+1).
  - State encodings BRU_IDLE/BRU_UPD/BRU_REC.
- One sub-module: bra_chk_fifo, the parameterized FIFO with push/pop/clear and occupancy. The FSM and output registers stay in bra_upd_ctl.

Test Plan:
- Reset, push PC 0x1000 taken, ghr 14'h0005, resolve taken -> next cycle PAs_up_en=1, torf=1, up_addr=0x1000, gshare_reen=0, occupancy 0.
- Push 3 entries (predicted 1,0,1), resolve first with 0 -> REC: gshare_reen=1, flush=1, re_GHR={ghr0[12:0],0}, torf=0, occupancy=0 that cycle.
- Fill 8 entries -> pre_ready=0, 9th push ignored. Resolve one correct -> pre_ready=1, occupancy 7.
- Push 20 entries interleaved with correct resolves -> FIFO order preserved across pointer wrap; up_addr sequence matches push order.
- res_valid held high continuously on 2 correct entries -> strobes in alternate cycles only, res_ready low in UPD. res_valid on empty queue -> no strobe.
- Drop reset mid-REC -> gshare_reen/flush low immediately, occupancy 0, pre_ready 1. With BRU_STATS_EN: after the above, stat_res/stat_mis match counts.
